// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU operation sequencer:
//               FSM state encoding, default datapath widths, named ALU op
//               codes and flag-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Default datapath widths of the shared ALU core.
    localparam int c_DATA_W = 8;
    localparam int c_RES_W  = 14;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } seq_state_t;

    // ALU operation codes (ALUControl).
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_MUL = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_SHR = 3'b111;

    // Flag-select codes (flagcontrol).
    localparam logic [1:0] c_FSEL_ZERO   = 2'b00;
    localparam logic [1:0] c_FSEL_CARRY  = 2'b01;
    localparam logic [1:0] c_FSEL_SIGN   = 2'b10;
    localparam logic [1:0] c_FSEL_PARITY = 2'b11;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone valid requester always
//               wins; when both are valid the one not granted last wins.
//               The history pointer only moves when i_advance is high.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_valid[1:0]    - request lines
//               i_advance       - grant was consumed (handshake this cycle)
//               o_grant[1:0]    - one-hot grant (all zero if no request)
//               o_grant_id      - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    // Index of the requester granted most recently. Resets to 1 so that
    // requester 0 is favoured first.
    logic r_last;
    logic w_id;

    always_comb begin
        w_id    = 1'b0;
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   w_id = 1'b0;
            2'b10:   w_id = 1'b1;
            2'b11:   w_id = ~r_last;
            default: w_id = 1'b0;
        endcase
        if (i_valid != 2'b00) begin
            o_grant = w_id ? 2'b10 : 2'b01;
        end
        o_grant_id = w_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_advance) begin
            r_last <= w_id;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Two-requester command front end for a shared ALU whose
//               operand port is time-multiplexed. A command is accepted from
//               the round-robin winner, A is loaded (alu_en_a), B is then
//               presented with the op for ALU_LAT cycles, and the result,
//               flag and overflow are captured and returned with the
//               requester id over a valid/ready response channel.
// Ports       : clk, rst                  - clock, async active-high reset
//               reqN_valid/ready          - command handshake, N = 0,1
//               reqN_op/fsel/a/b          - command fields
//               alu_in/en_a/ctrl/fsel     - ALU drive pins
//               alu_result/flag/ovf       - ALU outputs
//               rsp_valid/ready           - response handshake
//               rsp_id/result/flag/ovf    - response fields
//               busy                      - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int RES_W   = c_RES_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [1:0]        req0_fsel,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [1:0]        req1_fsel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_in,
    output logic              alu_en_a,
    output logic [2:0]        alu_ctrl,
    output logic [1:0]        alu_fsel,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_flag,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_flag,
    output logic              rsp_ovf,
    output logic              busy
);

    // ALU_LAT = 0 would leave no cycle in which B is presented.
    generate
        if (ALU_LAT < 1) begin : g_bad_lat
            $error("alu_op_sequencer: ALU_LAT must be >= 1");
        end
    endgenerate

    localparam int c_CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ALU_LAT - 1);

    seq_state_t r_state;
    seq_state_t w_state_next;

    logic [2:0]         r_op;
    logic [1:0]         r_fsel;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_id;
    logic [c_CNT_W-1:0] r_cnt;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [RES_W-1:0]   r_rsp_result;
    logic               r_rsp_flag;
    logic               r_rsp_ovf;

    logic       w_idle;
    logic [1:0] w_grant;
    logic       w_grant_id;
    logic       w_hs;
    logic       w_exec_last;

    // ------------------------------------------------------------------
    // Arbitration. Ready is offered only in IDLE; it is also masked while
    // reset is asserted so that every output reads 0 during reset.
    // ------------------------------------------------------------------
    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_valid    ({req1_valid, req0_valid}),
        .i_advance  (w_hs),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign w_idle      = (r_state == IDLE) && !rst;
    assign req0_ready  = w_idle && w_grant[0];
    assign req1_ready  = w_idle && w_grant[1];
    assign w_hs        = req0_ready || req1_ready;
    assign w_exec_last = (r_state == EXEC) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and ALU pin drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        alu_in       = '0;
        alu_en_a     = 1'b0;
        alu_ctrl     = 3'b000;
        alu_fsel     = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                alu_in       = r_a;
                alu_en_a     = 1'b1;
                alu_ctrl     = r_op;
                alu_fsel     = r_fsel;
                w_state_next = EXEC;
            end
            EXEC: begin
                alu_in   = r_b;
                alu_ctrl = r_op;
                alu_fsel = r_fsel;
                if (w_exec_last) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, EXEC down-counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= 3'b000;
            r_fsel       <= 2'b00;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flag   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            if (w_hs) begin
                // Only one ready can be high, so the grant id selects the
                // command source.
                r_id   <= w_grant_id;
                r_op   <= w_grant_id ? req1_op   : req0_op;
                r_fsel <= w_grant_id ? req1_fsel : req0_fsel;
                r_a    <= w_grant_id ? req1_a    : req0_a;
                r_b    <= w_grant_id ? req1_b    : req0_b;
            end

            if (r_state == LOAD_A) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_exec_last) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_id;
                r_rsp_result <= alu_result;
                r_rsp_flag   <= alu_flag;
                r_rsp_ovf    <= alu_ovf;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flag   = r_rsp_flag;
    assign rsp_ovf    = r_rsp_ovf;
    assign busy       = (r_state != IDLE);

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed self-checking bench for alu_op_sequencer. One
//               instance uses ALU_LAT=1 with a small ALU model; a second
//               instance uses ALU_LAT=3 with flag/overflow driven per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    int vectors    = 0;
    int miscompares = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- instance with ALU_LAT = 1 ----------------
    logic       r0v, r1v, rdy0, rdy1;
    logic [2:0] r0op, r1op;
    logic [1:0] r0fs, r1fs;
    logic [7:0] r0a, r0b, r1a, r1b;
    logic [7:0] alu_in1;
    logic       en1;
    logic [2:0] ctrl1;
    logic [1:0] fsel1;
    logic [13:0] res1;
    logic       flag1, ovf1;
    logic       rspv1, rsprdy1, rspid1, rspf1, rspo1, busy1;
    logic [13:0] rspres1;

    alu_op_sequencer #(.DATA_W(8), .RES_W(14), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(rdy0), .req0_op(r0op), .req0_fsel(r0fs),
        .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(rdy1), .req1_op(r1op), .req1_fsel(r1fs),
        .req1_a(r1a), .req1_b(r1b),
        .alu_in(alu_in1), .alu_en_a(en1), .alu_ctrl(ctrl1), .alu_fsel(fsel1),
        .alu_result(res1), .alu_flag(flag1), .alu_ovf(ovf1),
        .rsp_valid(rspv1), .rsp_ready(rsprdy1), .rsp_id(rspid1),
        .rsp_result(rspres1), .rsp_flag(rspf1), .rsp_ovf(rspo1), .busy(busy1)
    );

    // ---------------- instance with ALU_LAT = 3 ----------------
    logic       qv, q1v, rdy3_0, rdy3_1;
    logic [2:0] qop, q1op;
    logic [1:0] qfs, q1fs;
    logic [7:0] qa, qb, q1a, q1b;
    logic [7:0] alu_in3;
    logic       en3;
    logic [2:0] ctrl3;
    logic [1:0] fsel3;
    logic [13:0] res3;
    logic       flag3, ovf3;
    logic       rspv3, rr3, rspid3, rspf3, rspo3, busy3;
    logic [13:0] rspres3;

    alu_op_sequencer #(.DATA_W(8), .RES_W(14), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(qv), .req0_ready(rdy3_0), .req0_op(qop), .req0_fsel(qfs),
        .req0_a(qa), .req0_b(qb),
        .req1_valid(q1v), .req1_ready(rdy3_1), .req1_op(q1op), .req1_fsel(q1fs),
        .req1_a(q1a), .req1_b(q1b),
        .alu_in(alu_in3), .alu_en_a(en3), .alu_ctrl(ctrl3), .alu_fsel(fsel3),
        .alu_result(res3), .alu_flag(flag3), .alu_ovf(ovf3),
        .rsp_valid(rspv3), .rsp_ready(rr3), .rsp_id(rspid3),
        .rsp_result(rspres3), .rsp_flag(rspf3), .rsp_ovf(rspo3), .busy(busy3)
    );

    // ---------------- bench ALU model ----------------
    function automatic logic [13:0] alu_model(input logic [2:0] op,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        case (op)
            c_OP_ADD: alu_model = 14'(a) + 14'(b);
            c_OP_SUB: alu_model = 14'(a) - 14'(b);
            c_OP_AND: alu_model = 14'(a & b);
            c_OP_OR:  alu_model = 14'(a | b);
            c_OP_XOR: alu_model = 14'(a ^ b);
            c_OP_MUL: alu_model = prod[13:0];
            c_OP_SHL: alu_model = 14'(a) << b[2:0];
            default:  alu_model = 14'(a >> b[2:0]);
        endcase
    endfunction

    logic [7:0] ma1, ma3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma1 <= 8'd0;
            ma3 <= 8'd0;
        end else begin
            if (en1) ma1 <= alu_in1;
            if (en3) ma3 <= alu_in3;
        end
    end
    assign res1  = alu_model(ctrl1, ma1, alu_in1);
    assign flag1 = |res1[13:8];
    assign ovf1  = 1'b0;
    assign res3  = alu_model(ctrl3, ma3, alu_in3);

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r0v = 0; r1v = 0; r0op = 0; r1op = 0; r0fs = 0; r1fs = 0;
        r0a = 0; r0b = 0; r1a = 0; r1b = 0; rsprdy1 = 1'b1;
        qv = 0; q1v = 0; qop = 0; q1op = 0; qfs = 0; q1fs = 0;
        qa = 0; qb = 0; q1a = 0; q1b = 0; rr3 = 1'b1;
        flag3 = 0; ovf3 = 0;

        // ---- reset state ----
        tick(); tick();
        r0v = 1; r1v = 1; r0op = c_OP_ADD; r0a = 8'd1; r0b = 8'd2;
        #1;
        chk("rst_ready0", 32'(rdy0), 0);
        chk("rst_ready1", 32'(rdy1), 0);
        chk("rst_busy",   32'(busy1), 0);
        chk("rst_rspv",   32'(rspv1), 0);
        chk("rst_en_a",   32'(en1), 0);
        rst = 0;
        #1;
        chk("first_grant0", 32'(rdy0), 1);
        chk("first_grant1", 32'(rdy1), 0);

        // ---- reset mid-EXEC ----
        tick();                     // handshake req0
        tick();                     // now in EXEC
        chk("exec_busy", 32'(busy1), 1);
        rst = 1;
        #1;
        chk("midrst_busy", 32'(busy1), 0);
        chk("midrst_alu_in", 32'(alu_in1), 0);
        chk("midrst_ctrl", 32'(ctrl1), 0);
        chk("midrst_rspv", 32'(rspv1), 0);
        tick(); tick(); tick();
        rst = 0;
        #1;
        chk("postrst_ready0", 32'(rdy0), 1);
        chk("postrst_ready1", 32'(rdy1), 0);
        chk("postrst_rspv", 32'(rspv1), 0);

        // ---- single command 128 + 218 ----
        r1v = 0; r0op = c_OP_ADD; r0fs = c_FSEL_ZERO; r0a = 8'd128; r0b = 8'd218;
        #1;
        tick();                     // handshake
        chk("load_alu_in", 32'(alu_in1), 128);
        chk("load_en_a", 32'(en1), 1);
        chk("load_ready0", 32'(rdy0), 0);
        r0a = 8'd5; r0b = 8'd6; r0v = 0;   // change after handshake
        tick();
        chk("exec_alu_in", 32'(alu_in1), 218);
        chk("exec_en_a", 32'(en1), 0);
        chk("exec_rspv", 32'(rspv1), 0);
        tick();
        chk("resp_valid", 32'(rspv1), 1);
        chk("resp_result", 32'(rspres1), 346);
        chk("resp_id", 32'(rspid1), 0);
        chk("resp_flag", 32'(rspf1), 1);
        chk("resp_ovf", 32'(rspo1), 0);
        chk("resp_alu_in", 32'(alu_in1), 0);
        tick();
        chk("done_rspv", 32'(rspv1), 0);
        chk("done_busy", 32'(busy1), 0);

        // ---- alternating grants, both requesters valid ----
        rst = 1; tick(); rst = 0;
        r0op = c_OP_SUB; r0a = 8'd50;  r0b = 8'd20;
        r1op = c_OP_AND; r1a = 8'hF0;  r1b = 8'h3C;
        r0v = 1; r1v = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready0", 32'(rdy0), (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", 32'(rdy1), (i % 2 == 1) ? 1 : 0);
            tick(); tick(); tick();
            chk("rr_rspv", 32'(rspv1), 1);
            chk("rr_id", 32'(rspid1), i % 2);
            chk("rr_result", 32'(rspres1), (i % 2 == 1) ? 32'h30 : 32'd30);
            tick();
        end
        r0v = 0; r1v = 0;

        // ---- backpressure ----
        r0op = c_OP_ADD; r0a = 8'd1; r0b = 8'd2;
        r0v = 1; r1v = 1; rsprdy1 = 0;
        #1;
        chk("bp_ready0", 32'(rdy0), 1);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv", 32'(rspv1), 1);
            chk("bp_result", 32'(rspres1), 3);
            chk("bp_id", 32'(rspid1), 0);
            chk("bp_ready0", 32'(rdy0), 0);
            chk("bp_ready1", 32'(rdy1), 0);
            tick();
        end
        rsprdy1 = 1;
        tick();
        chk("bp_done_rspv", 32'(rspv1), 0);
        chk("bp_done_busy", 32'(busy1), 0);
        r0v = 0; r1v = 0;

        // ---- ALU_LAT = 3: op/fsel hold and last-cycle flag sampling ----
        qop = c_OP_OR; qfs = c_FSEL_PARITY; qa = 8'h0F; qb = 8'hF0; qv = 1;
        #1;
        chk("l3_ready0", 32'(rdy3_0), 1);
        tick();                     // handshake -> LOAD_A
        chk("l3_load_ctrl", 32'(ctrl3), 3);
        chk("l3_load_fsel", 32'(fsel3), 3);
        chk("l3_load_en", 32'(en3), 1);
        chk("l3_load_in", 32'(alu_in3), 32'h0F);
        qv = 0; qa = 8'h00; qb = 8'h00;
        flag3 = 0; ovf3 = 0;
        tick();                     // EXEC 1
        chk("l3_e1_ctrl", 32'(ctrl3), 3);
        chk("l3_e1_fsel", 32'(fsel3), 3);
        chk("l3_e1_in", 32'(alu_in3), 32'hF0);
        flag3 = 1; ovf3 = 0;
        tick();                     // EXEC 2
        chk("l3_e2_ctrl", 32'(ctrl3), 3);
        chk("l3_e2_fsel", 32'(fsel3), 3);
        flag3 = 0; ovf3 = 1;
        tick();                     // EXEC 3 (last)
        chk("l3_e3_ctrl", 32'(ctrl3), 3);
        chk("l3_e3_fsel", 32'(fsel3), 3);
        chk("l3_e3_rspv", 32'(rspv3), 0);
        flag3 = 1; ovf3 = 1;
        tick();                     // RESP
        chk("l3_rspv", 32'(rspv3), 1);
        chk("l3_result", 32'(rspres3), 32'hFF);
        chk("l3_flag", 32'(rspf3), 1);
        chk("l3_ovf", 32'(rspo3), 1);
        chk("l3_resp_ctrl", 32'(ctrl3), 0);
        chk("l3_id", 32'(rspid3), 0);
        flag3 = 0; ovf3 = 0;
        tick();
        chk("l3_done_rspv", 32'(rspv3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire
